packet_ctrl: RTL

PACKET_CTRL -- requirements
Module: packet_ctrl

---
 rtl/packet_ctrl_if.sv | 22 ++
 rtl/packet_ctrl.sv | 82 ++++++++
 2 files changed

// File: rtl/packet_ctrl_if.sv
// Byte-in / FIFO-out bundle for packet_ctrl: assembled-byte strobe, FIFO write port, status.
// master = packet_ctrl side, slave = byte source / FIFO / monitor side.
interface packet_ctrl_if;
  logic       byte_assembled;
  logic [7:0] data_byte;
  logic       fifo_full;
  logic       fifo_wr;
  logic [7:0] fifo_data;
  logic       pkt_done;
  logic       busy;
  logic [7:0] drop_cnt;

  modport master (
    input  byte_assembled, data_byte, fifo_full,
    output fifo_wr, fifo_data, pkt_done, busy, drop_cnt
  );

  modport slave (
    output byte_assembled, data_byte, fifo_full,
    input  fifo_wr, fifo_data, pkt_done, busy, drop_cnt
  );
endinterface

// File: rtl/packet_ctrl.sv
// Header hunt, PKT_LEN-byte capture with inter-byte timeout, then drain to FIFO; first write 1 cycle
// after the last byte strobe. fifo_full stalls the drain indefinitely; bytes arriving while draining are dropped.
module packet_ctrl #(
  parameter int PKT_LEN     = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic           clk,
  input logic           reset_n,
  packet_ctrl_if.master bus
);
  localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(PKT_LEN - 1);
  localparam logic [TW-1:0] TMO  = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] wr_ptr;
  logic [TW-1:0] timer;
  logic [7:0]    drop_cnt;
  logic [7:0]    pkt_buf [PKT_LEN];
  logic          wr;
  logic          is_hdr;

  assign is_hdr        = (bus.data_byte == 8'hA5) || (bus.data_byte == 8'hC3);
  assign wr            = (state == FLUSH) && !bus.fifo_full;
  assign bus.fifo_wr   = wr;
  assign bus.fifo_data = (state == FLUSH) ? pkt_buf[wr_ptr] : pkt_buf[0];
  assign bus.pkt_done  = wr && (wr_ptr == LAST);
  assign bus.busy      = (state != IDLE);
  assign bus.drop_cnt  = drop_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      wr_ptr   <= '0;
      timer    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < PKT_LEN; i++) pkt_buf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.byte_assembled && is_hdr) begin
            state <= COLLECT;
            idx   <= '0;
            timer <= '0;
          end
        end
        COLLECT: begin
          // A byte landing on the timeout cycle wins over the timeout.
          if (bus.byte_assembled) begin
            pkt_buf[idx] <= bus.data_byte;
            timer        <= '0;
            if (idx == LAST) begin
              state  <= FLUSH;
              wr_ptr <= '0;
              idx    <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (timer == TMO) begin
            state <= IDLE;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        FLUSH: begin
          if (bus.byte_assembled && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          if (wr) begin
            if (wr_ptr == LAST) state <= IDLE;
            else                wr_ptr <= wr_ptr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
